// File: rtl/dmux8_pkg.sv
// dmux8_pkg: shared widths, lane index constants and types for the 8-way 16-bit demux
//    WORD_W/LANES/SEL_W : lane data width, lane count, select width
//    lane_idx_t, word_t : lane index and data word types
//    LANE_A..LANE_Z     : lane indices in port order a,b,c,d,w,x,y,z
//    popcount8          : number of set bits in a lane mask
package dmux8_pkg;
   localparam int WORD_W = 16;
   localparam int LANES = 8;
   localparam int SEL_W = 3;
   typedef logic [SEL_W-1:0] lane_idx_t;
   typedef logic [WORD_W-1:0] word_t;
   localparam lane_idx_t LANE_A = 3'd0;
   localparam lane_idx_t LANE_B = 3'd1;
   localparam lane_idx_t LANE_C = 3'd2;
   localparam lane_idx_t LANE_D = 3'd3;
   localparam lane_idx_t LANE_W = 3'd4;
   localparam lane_idx_t LANE_X = 3'd5;
   localparam lane_idx_t LANE_Y = 3'd6;
   localparam lane_idx_t LANE_Z = 3'd7;
   function automatic logic [3:0] popcount8(input logic [LANES-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction
endpackage

// File: rtl/dmux_lane16.sv
// dmux_lane16: single-entry holding register for one demux lane
//    clk, rst_n : clock, synchronous active-low reset
//    push, din  : load din and mark the lane valid
//    pop        : consumer takes the word (ignored while empty)
//    valid,data : registered lane state; data is held after a pop
module dmux_lane16
   import dmux8_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  word_t din,
   input  logic  pop,
   output logic  valid,
   output word_t data
);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (push) data <= din;
         // a push in the same cycle as a pop keeps the lane full with the new word
         valid <= push | (valid & ~pop);
      end
   end
endmodule

// File: rtl/dmux8way16_stage.sv
// dmux8way16_stage: registered 1-to-8 demux of 16-bit words with per-lane valid/ready
//    clk, rst_n                  : clock, synchronous active-low reset
//    in_data/in_sel/in_valid     : producer word, destination lane, valid
//    in_ready                    : word accepted when in_valid & in_ready
//    in_auto                     : round-robin target select (only with DMUX8_AUTOSEL_EN)
//    out_a..out_z, out_valid     : lane data registers and their valid bits
//    out_ready                   : per-lane consumer take
//    lane_count                  : number of valid lanes
// Optional feature macro: DMUX8_AUTOSEL_EN
module dmux8way16_stage
   import dmux8_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  word_t            in_data,
   input  lane_idx_t        in_sel,
   input  logic             in_valid,
`ifdef DMUX8_AUTOSEL_EN
   input  logic             in_auto,
`endif
   output logic             in_ready,
   output word_t            out_a,
   output word_t            out_b,
   output word_t            out_c,
   output word_t            out_d,
   output word_t            out_w,
   output word_t            out_x,
   output word_t            out_y,
   output word_t            out_z,
   output logic [LANES-1:0] out_valid,
   input  logic [LANES-1:0] out_ready,
   output logic [3:0]       lane_count
);
   lane_idx_t        tgt;
   logic             push;
   logic [LANES-1:0] pops;
   word_t            lane_data [LANES];
`ifdef DMUX8_AUTOSEL_EN
   lane_idx_t        ptr;
   assign tgt = in_auto ? ptr : in_sel;
   always_ff @(posedge clk) begin
      if (!rst_n) ptr <= '0;
      else if (push && in_auto) ptr <= ptr + 3'd1;
   end
`else
   assign tgt = in_sel;
`endif
   assign in_ready = rst_n & (~out_valid[tgt] | out_ready[tgt]);
   assign push = in_valid & in_ready;
   assign pops = out_valid & out_ready;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      dmux_lane16 u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push && tgt == lane_idx_t'(i)),
         .din   (in_data),
         .pop   (pops[i]),
         .valid (out_valid[i]),
         .data  (lane_data[i])
      );
   end
   // correct handshakes keep the count within 0..8, so no saturation
   always_ff @(posedge clk) begin
      if (!rst_n) lane_count <= '0;
      else lane_count <= lane_count + {3'b000, push} - popcount8(pops);
   end
   assign out_a = lane_data[LANE_A];
   assign out_b = lane_data[LANE_B];
   assign out_c = lane_data[LANE_C];
   assign out_d = lane_data[LANE_D];
   assign out_w = lane_data[LANE_W];
   assign out_x = lane_data[LANE_X];
   assign out_y = lane_data[LANE_Y];
   assign out_z = lane_data[LANE_Z];
endmodule
